// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the 640x480 @ 60 Hz VGA sync generator and the colour
//   stage that sits between its address outputs and its colour input.
//   Contents:
//     - default timing constants (pixels / lines) and their line/frame totals
//     - blank address codes driven outside the visible area
//     - game-state encodings shared by the colour stage and the game FSM
//     - in_window(): inclusive range test used for the sync pulses
package vga_timing_pkg;

    localparam int CLK_DIV_DEF   = 4;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Out-of-range on purpose: the colour stage range check turns these into black.
    localparam logic [9:0] ADDRH_BLANK = 10'h3FF;
    localparam logic [8:0] ADDRV_BLANK = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        FAIL = 2'd3
    } game_state_t;

    function automatic logic in_window(input logic [9:0] cnt, input int lo, input int hi);
        return (cnt >= 10'(lo)) && (cnt <= 10'(hi));
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div
//   Divides the system clock down to the pixel rate.
//   Ports:
//     clk       system clock
//     reset     asynchronous, active-high
//     pix_tick  registered one-clk pulse, high while the divider sits at CLK_DIV-1
//     pix_pre   combinational, high the clk before pix_tick (lets the top
//               produce other pulses coincident with pix_tick)
//   CLK_DIV must be >= 2.
module vga_pix_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick,
    output logic pix_pre
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;

    assign pix_pre = (div == DW'(CLK_DIV - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            div      <= (div == DW'(CLK_DIV - 1)) ? '0 : div + 1'b1;
            pix_tick <= pix_pre;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   640x480 @ 60 Hz VGA timing generator wrapped around an external colour stage.
//   Ports:
//     clk         system clock (100 MHz)
//     reset       asynchronous, active-high
//     COLOUR_IN   {R,G,B} nibbles returned by the colour stage for ADDRH/ADDRV
//     ADDRH       visible column, ADDRH_BLANK in horizontal blanking
//     ADDRV       visible row, ADDRV_BLANK in vertical blanking
//     DISP_EN     high while ADDRH/ADDRV address a visible pixel
//     PIX_TICK    one-clk pulse per pixel period
//     FRAME_TICK  one-clk pulse per frame, coincident with the last PIX_TICK of it
//     HS, VS      sync pins, aligned with RGB
//     VGA_R/G/B   registered colour pins, black outside the visible area
//   Pipeline: on each PIX_TICK the counter value is presented as an address and
//   the counters step. The colour stage answers within one clk; its result is
//   sampled on the next PIX_TICK, together with the sync/enable bits computed
//   for the same pixel, so RGB/HS/VS trail the address by one pixel.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] COLOUR_IN,
    output logic [9:0]  ADDRH,
    output logic [8:0]  ADDRV,
    output logic        DISP_EN,
    output logic        PIX_TICK,
    output logic        FRAME_TICK,
    output logic        HS,
    output logic        VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic       pix_tick;
    logic       pix_pre;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;
    logic       h_vis;
    logic       v_vis;
    logic       hs_on;
    logic       vs_on;
    logic       hs_s1;
    logic       vs_s1;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pix_tick),
        .pix_pre  (pix_pre)
    );

    assign PIX_TICK = pix_tick;

    assign h_last = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));
    assign h_vis  = (h_cnt < 10'(H_VISIBLE));
    assign v_vis  = (v_cnt < 10'(V_VISIBLE));
    assign hs_on  = in_window(h_cnt, HS_START, HS_END);
    assign vs_on  = in_window(v_cnt, VS_START, VS_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            ADDRH      <= '0;
            ADDRV      <= '0;
            DISP_EN    <= 1'b0;
            FRAME_TICK <= 1'b0;
            hs_s1      <= ~SYNC_ACTIVE;
            vs_s1      <= ~SYNC_ACTIVE;
            HS         <= ~SYNC_ACTIVE;
            VS         <= ~SYNC_ACTIVE;
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
        end else begin
            // Counters only change on pix_tick edges, so checking them during
            // the pix_pre clk makes FRAME_TICK land on the same clk as PIX_TICK.
            FRAME_TICK <= pix_pre && h_last && v_last;

            if (pix_tick) begin
                h_cnt <= h_last ? '0 : h_cnt + 10'd1;
                if (h_last) begin
                    v_cnt <= v_last ? '0 : v_cnt + 10'd1;
                end

                // Stage 1: address and per-pixel attributes for h_cnt/v_cnt.
                ADDRH   <= h_vis ? h_cnt : ADDRH_BLANK;
                ADDRV   <= v_vis ? v_cnt[8:0] : ADDRV_BLANK;
                DISP_EN <= h_vis && v_vis;
                hs_s1   <= hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vs_s1   <= vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;

                // Stage 2: colour for the pixel addressed one period ago. DISP_EN
                // still holds that pixel's enable here, so it doubles as the
                // aligned blanking mask.
                HS <= hs_s1;
                VS <= vs_s1;
                {VGA_R, VGA_G, VGA_B} <= DISP_EN ? COLOUR_IN : 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: two instances share clk/reset. A reduced-timing instance
// (random colour stage, several frames) and a default-timing instance
// (COLOUR_IN tied to 12'hFFF, first lines only). Each clk the driver pushes the
// expected outputs of both instances; the monitor pops and compares.
module tb_vga_sync_gen;

    localparam int S_DIV = 3;
    localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 4;
    localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;

    typedef struct packed {
        logic [9:0]  addrh;
        logic [8:0]  addrv;
        logic        de;
        logic        pix;
        logic        frame;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int   dut;
        int   k;
        obs_t exp;
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [11:0] col_s;
    logic [11:0] col_b;
    logic [9:0]  s_addrh, b_addrh;
    logic [8:0]  s_addrv, b_addrv;
    logic        s_de, s_pix, s_frame, s_hs, s_vs;
    logic        b_de, b_pix, b_frame, b_hs, b_vs;
    logic [3:0]  s_r, s_g, s_b, b_r, b_g, b_b;
    obs_t        obs_s, obs_b;

    item_t sbq[$];
    int    checks = 0;
    int    errors = 0;
    int    colour_mode = 0;
    logic [11:0] key = 12'h000;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CLK_DIV (S_DIV), .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB), .SYNC_ACTIVE (1'b0)
    ) u_small (
        .clk (clk), .reset (reset), .COLOUR_IN (col_s),
        .ADDRH (s_addrh), .ADDRV (s_addrv), .DISP_EN (s_de), .PIX_TICK (s_pix),
        .FRAME_TICK (s_frame), .HS (s_hs), .VS (s_vs),
        .VGA_R (s_r), .VGA_G (s_g), .VGA_B (s_b)
    );

    vga_sync_gen u_big (
        .clk (clk), .reset (reset), .COLOUR_IN (col_b),
        .ADDRH (b_addrh), .ADDRV (b_addrv), .DISP_EN (b_de), .PIX_TICK (b_pix),
        .FRAME_TICK (b_frame), .HS (b_hs), .VS (b_vs),
        .VGA_R (b_r), .VGA_G (b_g), .VGA_B (b_b)
    );

    assign obs_s = {s_addrh, s_addrv, s_de, s_pix, s_frame, s_hs, s_vs, s_r, s_g, s_b};
    assign obs_b = {b_addrh, b_addrv, b_de, b_pix, b_frame, b_hs, b_vs, b_r, b_g, b_b};
    assign col_b = 12'hFFF;

    function automatic logic [11:0] colour_fn(input logic [9:0] ah, input logic [8:0] av,
                                              input int mode, input logic [11:0] ky);
        if (mode == 0) return {2'b00, ah};
        if (mode == 1) return {av[5:0], ah[5:0]} ^ ky;
        return 12'hFFF;
    endfunction

    // Colour stage model: one clk of latency from the address.
    always @(posedge clk) col_s <= colour_fn(s_addrh, s_addrv, colour_mode, key);

    // Expected outputs at the k-th clk after reset release (k < 0: in reset).
    // Tick edges occur every d clks starting at clk d; after m tick edges the
    // address shows pixel m-1 and the pins show pixel m-2 (raster order).
    function automatic obs_t model(input int k, input int d,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input int mode, input logic [11:0] ky);
        obs_t o;
        int ht, vt, m, p, h, v;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (k < 0) return o;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        m = k / d;
        o.pix = ((k % d) == d - 1);
        o.frame = o.pix && (((m + 1) % (ht * vt)) == 0);
        if (m >= 1) begin
            p = m - 1;
            h = p % ht;
            v = (p / ht) % vt;
            o.addrh = (h < hv) ? 10'(h) : 10'h3FF;
            o.addrv = (v < vv) ? 9'(v) : 9'h1FF;
            o.de    = (h < hv) && (v < vv);
        end
        if (m >= 2) begin
            p = m - 2;
            h = p % ht;
            v = (p / ht) % vt;
            o.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
            o.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
            if ((h < hv) && (v < vv)) o.rgb = colour_fn(10'(h), 9'(v), mode, ky);
        end
        return o;
    endfunction

    task automatic push_both(input int k);
        item_t it;
        it.dut = 0;
        it.k   = k;
        it.exp = model(k, S_DIV, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, colour_mode, key);
        sbq.push_back(it);
        it.dut = 1;
        it.exp = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 2, 12'h000);
        sbq.push_back(it);
    endtask

    task automatic check(input string name, input int dut, input int k,
                         input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d k=%0d got=%h expected=%h", name, dut, k, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        item_t it;
        obs_t  a;
        #1;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            a  = (it.dut == 0) ? obs_s : obs_b;
            check("ADDRH",      it.dut, it.k, 12'(a.addrh), 12'(it.exp.addrh));
            check("ADDRV",      it.dut, it.k, 12'(a.addrv), 12'(it.exp.addrv));
            check("DISP_EN",    it.dut, it.k, 12'(a.de),    12'(it.exp.de));
            check("PIX_TICK",   it.dut, it.k, 12'(a.pix),   12'(it.exp.pix));
            check("FRAME_TICK", it.dut, it.k, 12'(a.frame), 12'(it.exp.frame));
            check("HS",         it.dut, it.k, 12'(a.hs),    12'(it.exp.hs));
            check("VS",         it.dut, it.k, 12'(a.vs),    12'(it.exp.vs));
            check("RGB",        it.dut, it.k, a.rgb,        it.exp.rgb);
        end
    end

    // Driver
    initial begin
        int k;
        int rst_at;
        colour_mode = 0;
        key = 12'($urandom);
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            push_both(-1);
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        rst_at = $urandom_range(6800, 4800);
        while (k <= rst_at) begin
            push_both(k);
            @(negedge clk);
            k++;
        end

        // Asynchronous reset mid-frame, between clock edges.
        @(posedge clk);
        #2;
        reset = 1'b1;
        colour_mode = 1;
        key = 12'($urandom);
        repeat (5) begin
            @(negedge clk);
            push_both(-1);
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        while (k < 6600) begin
            push_both(k);
            @(negedge clk);
            k++;
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock.
- Drives ADDRH/ADDRV into the colour stage, samples that stage's 12-bit colour back, and drives the registered HS/VS/RGB pins.
- Sits directly around the colour stage: upstream as address source, downstream as pixel sink.
- Emits a per-frame tick for game-logic pacing.

Parameters:
- CLK_DIV, 4, system clocks per pixel; must be >= 2.
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_ACTIVE, 0, asserted level of HS/VS.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- COLOUR_IN  in  12  {R,G,B} nibbles from the colour stage for the current ADDRH/ADDRV
- ADDRH  out  10  visible column 0..639; 10'h3FF in horizontal blanking
- ADDRV  out  9  visible row 0..479; 9'h1FF in vertical blanking
- DISP_EN  out  1  high when ADDRH/ADDRV address a visible pixel
- PIX_TICK  out  1  one-clk pulse per pixel period
- FRAME_TICK  out  1  one-clk pulse per frame
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue

Behaviour:
- Reset (async):
  - div counter, h_cnt, v_cnt = 0.
  - ADDRH = 0, ADDRV = 0, DISP_EN = 0, PIX_TICK = 0, FRAME_TICK = 0.
  - HS = VS = ~SYNC_ACTIVE, RGB = 0.
  - Reset mid-frame aborts immediately; first pixel after release is (0,0).
- Pixel divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - PIX_TICK is registered, high for the clk where div == CLK_DIV-1.
  - First PIX_TICK occurs CLK_DIV clks after reset release.
- Counters: advance only on PIX_TICK.
  - H_TOTAL = 800, V_TOTAL = 525 (sum of the respective parameters).
  - h_cnt wraps at H_TOTAL-1 -> 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 -> 0.
  - v_cnt is 10 bits internally.
- Address outputs: registered, updated in the clk after each counter step, then held stable for the whole pixel period.
  - ADDRH = h_cnt if h_cnt < H_VISIBLE, else 10'h3FF.
  - ADDRV = v_cnt[8:0] if v_cnt < V_VISIBLE, else 9'h1FF.
  - Blanking codes fail the colour stage's range check, so it outputs black there.
- Colour pipeline:
  - The colour stage has up to 1 clk of latency. COLOUR_IN is sampled on the PIX_TICK clk, i.e. CLK_DIV-1 clks after the address update, which settles for CLK_DIV >= 2.
  - Sampled colour goes to VGA_R/G/B one pixel after its address was presented.
  - HS, VS and DISP_EN are each delayed one pixel internally so they align with RGB.
  - RGB is forced to 0 whenever the delayed display-enable is low, regardless of COLOUR_IN.
- Sync generation (before the alignment delay):
  - HS asserted for h_cnt in [656, 751].
  - VS asserted for v_cnt in [490, 491].
- FRAME_TICK: one clk pulse on the PIX_TICK where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, i.e. exactly once per 420000 pixels.
- Simultaneous line and frame wrap: both counters go to 0 on the same tick. No other state affected.
- All outputs registered; no combinational path from COLOUR_IN to the pins.

Decomposition:
- Shared package vga_timing_pkg holds:
  - timing constants and H_TOTAL/V_TOTAL;
  - blank codes ADDRH_BLANK = 10'h3FF and ADDRV_BLANK = 9'h1FF;
  - game-state encodings IDLE/PLAY/WIN/FAIL, so the colour stage and the state machine share them.
- One natural sub-module: vga_pix_div (divider producing PIX_TICK).
- Counters, sync and colour pipeline stay in the top.

Test Plan:
- Reset/startup: hold reset 10 clks, release -> all outputs at reset values; first PIX_TICK at clk 4; ADDRH=0, ADDRV=0, DISP_EN=1 after the first tick's update.
- Horizontal timing: run 2 lines -> PIX_TICK period 4 clks; line period 3200 clks; HS low for 96 pixels (384 clks), starting 656 pixels after line start plus 1-pixel alignment; ADDRH = 3FF for pixels 640..799.
- Vertical/frame: run 1 frame -> VS low for exactly 2 lines (lines 490-491); ADDRV = 1FF for lines 480..524; FRAME_TICK exactly once per 1,680,000 clks.
- Colour alignment: model the colour stage as COLOUR_IN = {2'b0, ADDRH[9:0]} with 1-clk lag -> each visible pixel's RGB equals the value derived from the previous pixel's ADDRH; no mismatches over a full line.
- Blanking mask: COLOUR_IN tied to 12'hFFF -> RGB = 12'hFFF only while aligned DE is high; RGB = 0 for all h >= 640 and v >= 480.
- Async reset mid-frame: assert reset at v=300, h=200 (between clk edges) -> outputs return to reset values immediately; after release, counting restarts from (0,0) with correct timing.
